writeback_unit: RTL and testbench



---
 rtl/writeback_unit_pkg.sv | 18 +
 rtl/wb_fifo.sv | 58 +++++
 rtl/writeback_unit.sv | 134 +++++++++++++
 tb/tb_writeback_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback path: data width default, source
// indices and the buffered writeback entry layout.
package writeback_unit_pkg;

  localparam int WB_XLEN = 32;
  localparam int WB_NSRC = 3;
  localparam int RD_W    = 5;

  localparam int SRC_INT = 0;
  localparam int SRC_FP  = 1;
  localparam int SRC_AGU = 2;

  typedef struct packed {
    logic [RD_W-1:0]    rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with flush. Head is read combinationally so the
// arbiter can see every source's oldest entry in the same cycle.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/writeback_unit.sv
// Buffers results from the int ALU, FP ALU and AGU, picks one per cycle
// round-robin and drives the register-file write port from a register stage.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN       = WB_XLEN,
  parameter int FIFO_DEPTH = 2,
  parameter int NSRC       = WB_NSRC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            alu_valid,
  input  logic [XLEN-1:0] alu_data,
  input  logic [4:0]      alu_rd,
  output logic            alu_ready,
  input  logic            fpu_valid,
  input  logic [XLEN-1:0] fpu_data,
  input  logic [4:0]      fpu_rd,
  output logic            fpu_ready,
  input  logic            agu_valid,
  input  logic [XLEN-1:0] agu_data,
  input  logic [4:0]      agu_rd,
  output logic            agu_ready,
  output logic            rf_we,
  output logic            rf_fwe,
  output logic [4:0]      rf_rd,
  output logic [XLEN:0]   rf_data,
  output logic            retire_valid,
  output logic [1:0]      retire_src
);

  localparam int EW = XLEN + RD_W;

  logic [NSRC-1:0] src_valid;
  logic [NSRC-1:0] src_push;
  logic [NSRC-1:0] src_pop;
  logic [NSRC-1:0] src_full;
  logic [NSRC-1:0] src_empty;
  logic [EW-1:0]   src_entry [NSRC];
  logic [EW-1:0]   src_head  [NSRC];

  logic [1:0]      ptr_reg;
  logic [1:0]      ptr_next;
  logic [1:0]      grant_idx;
  logic            grant_found;
  logic            grant;
  logic [EW-1:0]   grant_head;
  logic [4:0]      grant_rd;
  logic [XLEN-1:0] grant_data;

  assign src_valid    = {agu_valid, fpu_valid, alu_valid};
  assign src_entry[0] = {alu_rd, alu_data};
  assign src_entry[1] = {fpu_rd, fpu_data};
  assign src_entry[2] = {agu_rd, agu_data};

  // Ready is purely occupancy based so producers never see a valid->ready loop.
  assign alu_ready = !src_full[SRC_INT];
  assign fpu_ready = !src_full[SRC_FP];
  assign agu_ready = !src_full[SRC_AGU];

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign src_push[gi] = src_valid[gi] && !src_full[gi] && !flush;
      assign src_pop[gi]  = grant && (grant_idx == 2'(gi));

      wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (src_push[gi]),
        .pop   (src_pop[gi]),
        .din   (src_entry[gi]),
        .head  (src_head[gi]),
        .full  (src_full[gi]),
        .empty (src_empty[gi])
      );
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NSRC; k++) begin
      int idx;
      idx = (int'(ptr_reg) + k) % NSRC;
      if (!grant_found && !src_empty[idx]) begin
        grant_found = 1'b1;
        grant_idx   = 2'(idx);
      end
    end
  end

  assign grant      = grant_found && !flush;
  assign grant_head = src_head[grant_idx];
  assign grant_rd   = grant_head[EW-1:XLEN];
  assign grant_data = grant_head[XLEN-1:0];

  always_comb begin
    ptr_next = ptr_reg;
    if (grant) ptr_next = (grant_idx == 2'(NSRC-1)) ? 2'd0 : grant_idx + 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg      <= '0;
      rf_we        <= 1'b0;
      rf_fwe       <= 1'b0;
      retire_valid <= 1'b0;
      rf_rd        <= '0;
      rf_data      <= '0;
      retire_src   <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (grant) begin
        // x0 writes still retire so downstream bookkeeping sees them.
        rf_we        <= (grant_idx != 2'(SRC_FP)) && (grant_rd != 5'd0);
        rf_fwe       <= (grant_idx == 2'(SRC_FP));
        retire_valid <= 1'b1;
        rf_rd        <= grant_rd;
        rf_data      <= {1'b0, grant_data};
        retire_src   <= grant_idx;
      end else begin
        rf_we        <= 1'b0;
        rf_fwe       <= 1'b0;
        retire_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a list-based model of the per-source buffers and round-robin pick.
module tb_writeback_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        vld [3];
  logic [31:0] dat [3];
  logic [4:0]  rdv [3];
  logic        rdy [3];
  logic        rf_we, rf_fwe, retire_valid;
  logic [4:0]  rf_rd;
  logic [32:0] rf_data;
  logic [1:0]  retire_src;

  int checks = 0;
  int errors = 0;

  // reference model state
  ent_t        mbuf [3][0:7];
  int          mcnt [3];
  int          mptr;
  logic        exp_we, exp_fwe, exp_rv;
  logic [4:0]  exp_rd;
  logic [32:0] exp_data;
  logic [1:0]  exp_src;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .alu_valid    (vld[0]),
    .alu_data     (dat[0]),
    .alu_rd       (rdv[0]),
    .alu_ready    (rdy[0]),
    .fpu_valid    (vld[1]),
    .fpu_data     (dat[1]),
    .fpu_rd       (rdv[1]),
    .fpu_ready    (rdy[1]),
    .agu_valid    (vld[2]),
    .agu_data     (dat[2]),
    .agu_rd       (rdv[2]),
    .agu_ready    (rdy[2]),
    .rf_we        (rf_we),
    .rf_fwe       (rf_fwe),
    .rf_rd        (rf_rd),
    .rf_data      (rf_data),
    .retire_valid (retire_valid),
    .retire_src   (retire_src)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) mcnt[s] = 0;
    mptr = 0;
    exp_we = 0; exp_fwe = 0; exp_rv = 0;
    exp_rd = '0; exp_data = '0; exp_src = '0;
  endtask

  task automatic idle();
    flush = 1'b0;
    for (int s = 0; s < 3; s++) begin
      vld[s] = 1'b0; dat[s] = '0; rdv[s] = '0;
    end
  endtask

  task automatic set_src(input int s, input logic [4:0] rd, input logic [31:0] d);
    vld[s] = 1'b1; rdv[s] = rd; dat[s] = d;
  endtask

  // Called just after a falling edge with inputs applied: checks ready,
  // predicts the coming rising edge, then compares outputs just after it.
  task automatic step();
    bit   can_take [3];
    int   g;
    ent_t e;
    for (int s = 0; s < 3; s++) begin
      can_take[s] = (mcnt[s] < DEPTH);
      check($sformatf("ready%0d", s), 64'(rdy[s]), 64'(can_take[s]));
    end
    g = -1;
    if (flush) begin
      exp_we = 0; exp_fwe = 0; exp_rv = 0;
      for (int s = 0; s < 3; s++) mcnt[s] = 0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (g < 0 && mcnt[(mptr + k) % 3] > 0) g = (mptr + k) % 3;
      if (g >= 0) begin
        e = mbuf[g][0];
        for (int i = 0; i < 7; i++) mbuf[g][i] = mbuf[g][i+1];
        mcnt[g]--;
        exp_rd = e.rd; exp_data = {1'b0, e.data}; exp_src = 2'(g);
        exp_rv = 1; exp_fwe = (g == 1); exp_we = (g != 1) && (e.rd != 0);
        mptr = (g + 1) % 3;
      end else begin
        exp_we = 0; exp_fwe = 0; exp_rv = 0;
      end
      for (int s = 0; s < 3; s++)
        if (vld[s] && can_take[s]) begin
          mbuf[s][mcnt[s]] = '{rd: rdv[s], data: dat[s]};
          mcnt[s]++;
        end
    end
    @(posedge clk);
    #1;
    check("rf_we", 64'(rf_we), 64'(exp_we));
    check("rf_fwe", 64'(rf_fwe), 64'(exp_fwe));
    check("retire_valid", 64'(retire_valid), 64'(exp_rv));
    check("rf_rd", 64'(rf_rd), 64'(exp_rd));
    check("rf_data", 64'(rf_data), 64'(exp_data));
    check("retire_src", 64'(retire_src), 64'(exp_src));
    if (exp_rv)
      $display("retire src=%0d rd=%0d data=%09h we=%0b fwe=%0b",
               exp_src, exp_rd, exp_data, exp_we, exp_fwe);
    @(negedge clk);
  endtask

  initial begin
    int sent;
    int cyc;
    idle();
    model_reset();
    #12;
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_rv", 64'(retire_valid), 64'd0);
    check("rst_data", 64'(rf_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) check($sformatf("rst_ready%0d", s), 64'(rdy[s]), 64'd1);
    @(negedge clk);

    // three sources in one cycle, pointer at 0
    set_src(0, 5'd1, 32'h11); set_src(1, 5'd2, 32'h22); set_src(2, 5'd3, 32'h33);
    step();
    idle();
    step(); check("t3_src0", 64'(retire_src), 64'd0); check("t3_we", 64'(rf_we), 64'd1);
    step(); check("t3_src1", 64'(retire_src), 64'd1); check("t3_fwe", 64'(rf_fwe), 64'd1);
    step(); check("t3_src2", 64'(retire_src), 64'd2); check("t3_data", 64'(rf_data), 64'h33);
    step();

    // single int result, two edges to the write port
    set_src(0, 5'd5, 32'h0000_00AA);
    step();
    idle();
    step();
    check("t1_we", 64'(rf_we), 64'd1);
    check("t1_rd", 64'(rf_rd), 64'd5);
    check("t1_data", 64'(rf_data), 64'h0_0000_00AA);
    step();
    check("t1_pulse", 64'(rf_we), 64'd0);

    // x0 destination retires without a write
    set_src(0, 5'd0, 32'hFFFF_FFFF);
    step();
    idle();
    step();
    check("x0_rv", 64'(retire_valid), 64'd1);
    check("x0_we", 64'(rf_we), 64'd0);
    check("x0_fwe", 64'(rf_fwe), 64'd0);

    // int streams four results while FP is also busy
    set_src(1, 5'd9, 32'hF0); step();
    set_src(1, 5'd10, 32'hF1); step();
    vld[1] = 1'b0;
    sent = 0;
    cyc = 0;
    while (sent < 4 && cyc < 30) begin
      set_src(0, 5'(12 + sent), 32'hA0 + 32'(sent));
      if (rdy[0]) sent++;
      step();
      cyc++;
    end
    check("stream_sent", 64'(sent), 64'd4);
    idle();
    for (int i = 0; i < 6; i++) step();

    // fill everything, then flush with an AGU result in flight
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 3; s++) set_src(s, 5'(20 + i), 32'(s * 16 + i));
      step();
    end
    idle();
    flush = 1'b1;
    set_src(2, 5'd31, 32'hDEAD_BEEF);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_flush_rv", 64'(retire_valid), 64'd0);
    end

    // asynchronous reset between edges while writes are active
    set_src(0, 5'd7, 32'h77); step();
    set_src(0, 5'd8, 32'h88); step();
    check("pre_rst_we", 64'(rf_we), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_we", 64'(rf_we), 64'd0);
    check("arst_rv", 64'(retire_valid), 64'd0);
    check("arst_data", 64'(rf_data), 64'd0);
    model_reset();
    idle();
    @(negedge clk);
    reset = 1'b0;
    set_src(2, 5'd4, 32'h4444);
    step();
    idle();
    step();
    check("rec_we", 64'(rf_we), 64'd1);
    check("rec_data", 64'(rf_data), 64'h4444);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 3; s++) begin
        vld[s] = ($urandom_range(0, 99) < 60);
        rdv[s] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        dat[s] = $urandom;
      end
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
